// File: rtl/alu_pkg.sv
// Shared definitions for the main_alu datapath.
//   OP_*        : opcode encodings on the 2-bit OPCode port
//   ALU_W       : operand/result width (fixed at 8)
//   div_state_t : sequential divider control states
//   alu_res_t   : bundled {Y, Z, O, C} result
//   alu_arith() : single-cycle add/sub/mul result and flags
package alu_pkg;

  localparam int unsigned ALU_W = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic {
    DIV_IDLE,
    DIV_RUN
  } div_state_t;

  typedef struct packed {
    logic [ALU_W-1:0] y;
    logic [ALU_W-1:0] z;
    logic             o;
    logic             c;
  } alu_res_t;

  // Combinational result for the three single-cycle operations. The divide
  // opcode returns all zeros; its result comes from the sequential divider.
  function automatic alu_res_t alu_arith(input logic [1:0]       op,
                                         input logic [ALU_W-1:0] a,
                                         input logic [ALU_W-1:0] b);
    alu_res_t           r;
    logic [ALU_W:0]     sum;
    logic [ALU_W:0]     diff;
    logic [2*ALU_W-1:0] prod;
    r    = '0;
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    prod = {{ALU_W{1'b0}}, a} * {{ALU_W{1'b0}}, b};
    case (op)
      OP_ADD: begin
        r.y = sum[ALU_W-1:0];
        r.c = sum[ALU_W];
        r.o = (a[ALU_W-1] == b[ALU_W-1]) && (sum[ALU_W-1] != a[ALU_W-1]);
      end
      OP_SUB: begin
        r.y = diff[ALU_W-1:0];
        // Bit 8 of the 9-bit wrapped difference is set exactly when a < b.
        r.c = diff[ALU_W];
        r.o = (a[ALU_W-1] != b[ALU_W-1]) && (diff[ALU_W-1] != a[ALU_W-1]);
      end
      OP_MUL: begin
        r.y = prod[ALU_W-1:0];
        r.z = prod[2*ALU_W-1:ALU_W];
        r.o = |prod[2*ALU_W-1:ALU_W];
        r.c = |prod[2*ALU_W-1:ALU_W];
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_seq_divider.sv
// Restoring shift/subtract divider, one quotient bit per clock.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   start        : load dividend/divisor and begin (honoured only when idle)
//   abort        : drop an in-flight division and return to idle
//   dividend     : numerator captured on start
//   divisor      : denominator captured on start
//   busy         : a division is in progress
//   done         : high for the single cycle whose closing edge performs the
//                  final iteration; quotient/remainder are valid with it
//   quotient     : result of the final step (valid while done)
//   remainder    : result of the final step (valid while done)
//   div0         : the division in progress has a zero divisor
module alu_seq_divider
  import alu_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [ALU_W-1:0] dividend,
  input  logic [ALU_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [ALU_W-1:0] quotient,
  output logic [ALU_W-1:0] remainder,
  output logic             div0
);

  localparam logic [2:0] LAST_STEP = 3'(ALU_W - 1);

  div_state_t       state, state_n;
  logic [2:0]       count, count_n;
  logic [ALU_W-1:0] rem, rem_n;
  logic [ALU_W-1:0] quo, quo_n;
  logic [ALU_W-1:0] dvsr, dvsr_n;
  logic             div0_q, div0_n;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor when it fits.
  logic [ALU_W:0]   shifted;
  logic [ALU_W:0]   trial;
  logic             fits;
  logic [ALU_W-1:0] step_rem;
  logic [ALU_W-1:0] step_quo;

  always_comb begin
    shifted  = {rem, quo[ALU_W-1]};
    trial    = shifted - {1'b0, dvsr};
    fits     = (shifted >= {1'b0, dvsr});
    step_rem = fits ? trial[ALU_W-1:0] : shifted[ALU_W-1:0];
    step_quo = {quo[ALU_W-2:0], fits};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= DIV_IDLE;
      count  <= '0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
      div0_q <= 1'b0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      rem    <= rem_n;
      quo    <= quo_n;
      dvsr   <= dvsr_n;
      div0_q <= div0_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    rem_n   = rem;
    quo_n   = quo;
    dvsr_n  = dvsr;
    div0_n  = div0_q;
    case (state)
      DIV_IDLE: begin
        if (start) begin
          state_n = DIV_RUN;
          count_n = '0;
          rem_n   = '0;
          quo_n   = dividend;
          dvsr_n  = divisor;
          div0_n  = (divisor == '0);
        end
      end
      DIV_RUN: begin
        if (abort) begin
          state_n = DIV_IDLE;
        end else begin
          rem_n   = step_rem;
          quo_n   = step_quo;
          count_n = count + 3'd1;
          if (count == LAST_STEP) state_n = DIV_IDLE;
        end
      end
      default: state_n = DIV_IDLE;
    endcase
  end

  // With a zero divisor every trial subtraction fits, so the algorithm
  // itself yields quotient = all ones and remainder = dividend.
  always_comb begin
    busy      = (state == DIV_RUN);
    done      = (state == DIV_RUN) && (count == LAST_STEP) && !abort;
    quotient  = step_quo;
    remainder = step_rem;
    div0      = div0_q;
  end

endmodule

// File: rtl/main_alu.sv
// 8-bit four-function ALU: add, sub and mul in one registered cycle,
// divide through a sequential restoring divider.
//   clock  : rising-edge clock
//   reset  : synchronous active-high reset
//   OPCode : 00 add, 01 sub, 10 mul, 11 div
//   A, B   : unsigned operands (dividend, divisor for div)
//   Y      : primary result (sum, difference, low product, quotient)
//   Z      : secondary result (high product, remainder, else 0)
//   O      : signed overflow / multiply high-nonzero / divide-by-zero
//   C      : carry / borrow / multiply high-nonzero
module main_alu
  import alu_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       OPCode,
  input  logic [ALU_W-1:0] A,
  input  logic [ALU_W-1:0] B,
  output logic [ALU_W-1:0] Y,
  output logic [ALU_W-1:0] Z,
  output logic             O,
  output logic             C
);

  logic [1:0]       prev_op;
  logic [ALU_W-1:0] cap_a;
  logic [ALU_W-1:0] cap_b;

  logic             is_div;
  logic             launch;
  logic             abort;
  alu_res_t         arith;

  logic             div_busy;
  logic             div_done;
  logic [ALU_W-1:0] div_q;
  logic [ALU_W-1:0] div_r;
  logic             div_zero;

  // A divide is (re)launched only when the divider is idle and the request
  // is new: either the opcode just became div or the operands changed since
  // the last launch. Holding div with the same operands leaves the outputs
  // on the previous quotient/remainder.
  always_comb begin
    is_div = (OPCode == OP_DIV);
    launch = is_div && !div_busy &&
             ((prev_op != OP_DIV) || ({A, B} != {cap_a, cap_b}));
    abort  = div_busy && !is_div;
    arith  = alu_arith(OPCode, A, B);
  end

  alu_seq_divider u_div (
    .clock     (clock),
    .reset     (reset),
    .start     (launch),
    .abort     (abort),
    .dividend  (A),
    .divisor   (B),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r),
    .div0      (div_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      Y       <= '0;
      Z       <= '0;
      O       <= 1'b0;
      C       <= 1'b0;
      prev_op <= OP_ADD;
      cap_a   <= '0;
      cap_b   <= '0;
    end else begin
      prev_op <= OPCode;
      if (launch) begin
        cap_a <= A;
        cap_b <= B;
      end
      if (!is_div) begin
        // Also covers leaving div mid-division: the new result lands on the
        // same edge that aborts the divider.
        Y <= arith.y;
        Z <= arith.z;
        O <= arith.o;
        C <= arith.c;
      end else if (div_done) begin
        Y <= div_q;
        Z <= div_r;
        O <= div_zero;
        C <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_main_alu.sv
module tb_main_alu;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] OPCode;
  logic [7:0] A, B;
  logic [7:0] Y, Z;
  logic       O, C;

  always #5 clock = ~clock;

  main_alu dut (
    .clock  (clock),
    .reset  (reset),
    .OPCode (OPCode),
    .A      (A),
    .B      (B),
    .Y      (Y),
    .Z      (Z),
    .O      (O),
    .C      (C)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: outputs, last sampled opcode, operands of the
  // last launched division and edges left until it completes.
  logic [7:0] m_y, m_z;
  logic       m_o, m_c;
  int         m_prev;
  int         m_cap_a, m_cap_b;
  int         m_left;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a, b;
    logic [7:0] y, z;
    logic       o, c;
  } vec_t;

  vec_t vecs[10];

  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%02h want=%02h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk4(input string name, input logic [7:0] y, input logic [7:0] z,
                      input logic o, input logic c);
    chk({name, ".Y"}, Y, y);
    chk({name, ".Z"}, Z, z);
    chk({name, ".O"}, {7'd0, O}, {7'd0, o});
    chk({name, ".C"}, {7'd0, C}, {7'd0, c});
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    int a, b, op, r, s;
    a  = int'(A);
    b  = int'(B);
    op = int'(OPCode);
    if (reset) begin
      m_y = 0; m_z = 0; m_o = 0; m_c = 0;
      m_prev = 0; m_cap_a = 0; m_cap_b = 0; m_left = 0;
      return;
    end
    if (op != 3) begin
      m_left = 0;
      case (op)
        0: begin
          r = a + b; s = sx(a) + sx(b);
          m_y = 8'(r); m_z = 0; m_c = (r > 255); m_o = (s > 127 || s < -128);
        end
        1: begin
          r = a - b; s = sx(a) - sx(b);
          m_y = 8'(r); m_z = 0; m_c = (a < b); m_o = (s > 127 || s < -128);
        end
        default: begin
          r = a * b;
          m_y = 8'(r % 256); m_z = 8'(r / 256); m_c = (r > 255); m_o = (r > 255);
        end
      endcase
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        if (m_cap_b == 0) begin
          m_y = 8'hFF; m_z = 8'(m_cap_a); m_o = 1; m_c = 0;
        end else begin
          m_y = 8'(m_cap_a / m_cap_b); m_z = 8'(m_cap_a % m_cap_b); m_o = 0; m_c = 0;
        end
      end
    end else if (m_prev != 3 || a != m_cap_a || b != m_cap_b) begin
      m_cap_a = a; m_cap_b = b; m_left = 8;
    end
    m_prev = op;
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    OPCode = op; A = a; B = b;
  endtask

  initial begin
    logic [7:0] hy, hz;
    logic       ho, hc;

    vecs[0] = '{2'b00, 8'h13, 8'h2C, 8'h3F, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{2'b00, 8'h7F, 8'h05, 8'h84, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{2'b00, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{2'b01, 8'h7F, 8'h01, 8'h7E, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{2'b01, 8'h00, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b1};
    vecs[5] = '{2'b01, 8'h80, 8'h01, 8'h7F, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{2'b10, 8'h7F, 8'h01, 8'h7F, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{2'b10, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 1'b1};
    vecs[8] = '{2'b01, 8'h10, 8'h20, 8'hF0, 8'h00, 1'b0, 1'b1};
    vecs[9] = '{2'b10, 8'h10, 8'h10, 8'h00, 8'h01, 1'b1, 1'b1};

    reset = 1'b1;
    drive(2'b11, 8'h12, 8'h34);
    #1;
    step();
    step();
    chk4("reset", 8'h00, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;

    // Single-cycle operations, back to back with no bubble.
    for (int unsigned i = 0; i < 10; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      step();
      chk4($sformatf("vec%0d", i), vecs[i].y, vecs[i].z, vecs[i].o, vecs[i].c);
    end

    // Divide 04/03: outputs hold through L..L+7, update exactly at L+8.
    hy = Y; hz = Z; ho = O; hc = C;
    drive(2'b11, 8'h04, 8'h03);
    for (int unsigned k = 0; k < 8; k++) begin
      step();
      chk4($sformatf("div_hold%0d", k), hy, hz, ho, hc);
    end
    step();
    chk4("div_4_3", 8'h01, 8'h01, 1'b0, 1'b0);

    // Operand change relaunches.
    drive(2'b11, 8'h7F, 8'h08);
    for (int unsigned k = 0; k < 9; k++) step();
    chk4("div_7f_8", 8'h0F, 8'h07, 1'b0, 1'b0);

    // Holding the inputs must not relaunch or change anything.
    for (int unsigned k = 0; k < 12; k++) begin
      step();
      chk4($sformatf("div_steady%0d", k), 8'h0F, 8'h07, 1'b0, 1'b0);
    end

    // Divide by zero, same latency.
    drive(2'b11, 8'h55, 8'h00);
    for (int unsigned k = 0; k < 8; k++) step();
    chk4("div0_early", 8'h0F, 8'h07, 1'b0, 1'b0);
    step();
    chk4("div0", 8'hFF, 8'h55, 1'b1, 1'b0);

    // Abort: launch, then opcode 00 sampled at L+3.
    drive(2'b11, 8'h20, 8'h03);
    step();
    step();
    step();
    drive(2'b00, 8'h20, 8'h03);
    step();
    chk4("abort_add", 8'h23, 8'h00, 1'b0, 1'b0);
    for (int unsigned k = 0; k < 8; k++) begin
      step();
      chk4($sformatf("abort_after%0d", k), 8'h23, 8'h00, 1'b0, 1'b0);
    end

    // Randomized traffic against the model; operands are often held so that
    // divisions run to completion and hold cases occur.
    for (int unsigned n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 99) < 25) begin
        if ($urandom_range(0, 2) == 0) OPCode = 2'($urandom_range(0, 3));
        else OPCode = 2'b11;
        A = 8'($urandom);
        B = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      end
      step();
      chk4("rand", m_y, m_z, m_o, m_c);
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
